// File: rtl/lock_ctrl_pkg.sv
// Shared definitions for the debug unlock control slice:
// FSM state codes, default key words and the fail-counter width helper.
package lock_ctrl_pkg;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_K1  = 2'd1;
  localparam logic [1:0] S_UNLOCKED = 2'd2;
  localparam logic [1:0] S_LOCKOUT  = 2'd3;

  localparam logic [15:0] KEY0_DEF = 16'hA5C3;
  localparam logic [15:0] KEY1_DEF = 16'h3C5A;

  function automatic int fail_width(input int max_fails);
    return $clog2(max_fails + 1);
  endfunction

endpackage

// File: rtl/sat_down_counter.sv
// Loadable down counter that stops at zero and flags its last
// count (value 1).
module sat_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == W'(1));

endmodule

// File: rtl/debug_unlock_ctrl.sv
// Key-sequence unlock FSM with bounded debug window, fail lockout
// and a one-shot Lock pulse for the lockable data register.
module debug_unlock_ctrl
  import lock_ctrl_pkg::*;
#(
  parameter int            DW            = 16,
  parameter logic [DW-1:0] KEY0          = DW'(KEY0_DEF),
  parameter logic [DW-1:0] KEY1          = DW'(KEY1_DEF),
  parameter int            TIMEOUT       = 8,
  parameter int            UNLOCK_CYCLES = 64,
  parameter int            MAX_FAILS     = 3,
  parameter int            FW            = fail_width(MAX_FAILS)
) (
  input  logic          Clk,
  input  logic          resetn,
  input  logic [DW-1:0] key_in,
  input  logic          key_valid,
  input  logic          lock_req,
  input  logic          relock,
  input  logic          scan_mode,
  output logic          Lock,
  output logic          debug_unlocked,
  output logic          lockout,
  output logic [FW-1:0] fail_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int WW = $clog2(UNLOCK_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [FW-1:0] F_MAX  = FW'(MAX_FAILS);

  logic [1:0]    state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic [FW-1:0] fail_nxt;
  logic          fail;
  logic          win_load, win_clr, win_exp;
  logic          lock_issued, lock_trig;

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    fail_nxt  = fail_cnt;
    fail      = 1'b0;
    win_load  = 1'b0;
    win_clr   = 1'b0;
    if (state == S_LOCKOUT) begin
      state_nxt = S_LOCKOUT;
    end else if (scan_mode) begin
      state_nxt = S_IDLE;
      timer_nxt = '0;
      win_clr   = 1'b1;
    end else begin
      unique case (state)
        S_UNLOCKED: begin
          if (relock || lock_req || win_exp) begin
            state_nxt = S_IDLE;
            win_clr   = 1'b1;
          end
        end
        S_WAIT_K1: begin
          if (key_valid) begin
            if (key_in == KEY1) begin
              state_nxt = S_UNLOCKED;
              win_load  = 1'b1;
              fail_nxt  = '0;
            end else begin
              state_nxt = S_IDLE;
              fail      = 1'b1;
            end
            timer_nxt = '0;
          end else if (timer == T_LAST) begin
            state_nxt = S_IDLE;
            timer_nxt = '0;
            fail      = 1'b1;
          end else begin
            timer_nxt = timer + 1'b1;
          end
        end
        default: begin
          if (key_valid) begin
            if (key_in == KEY0) begin
              state_nxt = S_WAIT_K1;
              timer_nxt = '0;
            end else begin
              fail = 1'b1;
            end
          end
        end
      endcase
    end
    // a fail reaching the limit overrides any IDLE target
    if (fail) begin
      fail_nxt = (fail_cnt == F_MAX) ? F_MAX : fail_cnt + 1'b1;
      if (fail_nxt == F_MAX) state_nxt = S_LOCKOUT;
    end
  end

  assign lock_trig = lock_req ||
    (state_nxt == S_LOCKOUT && state != S_LOCKOUT);

  always_ff @(posedge Clk) begin
    if (!resetn) begin
      state          <= S_IDLE;
      timer          <= '0;
      fail_cnt       <= '0;
      Lock           <= 1'b0;
      lock_issued    <= 1'b0;
      debug_unlocked <= 1'b0;
      lockout        <= 1'b0;
    end else begin
      state          <= state_nxt;
      timer          <= timer_nxt;
      fail_cnt       <= fail_nxt;
      Lock           <= lock_trig && !lock_issued;
      lock_issued    <= lock_issued || lock_trig;
      debug_unlocked <= (state_nxt == S_UNLOCKED);
      lockout        <= (state_nxt == S_LOCKOUT);
    end
  end

  sat_down_counter #(
    .W (WW)
  ) u_win (
    .clk      (Clk),
    .resetn   (resetn),
    .clear    (win_clr),
    .load     (win_load),
    .load_val (WW'(UNLOCK_CYCLES)),
    .en       (state == S_UNLOCKED),
    .expired  (win_exp)
  );

endmodule

// File: tb/tb_debug_unlock_ctrl.sv
// Scoreboard bench for debug_unlock_ctrl: deadline-based reference
// model feeds an expected-output queue drained by a monitor.
module tb_debug_unlock_ctrl;

  localparam int TIMEOUT = 8;
  localparam int UC      = 64;
  localparam int MAXF    = 3;
  localparam int FW      = 2;
  localparam logic [15:0] K0 = 16'hA5C3;
  localparam logic [15:0] K1 = 16'h3C5A;

  logic          Clk;
  logic          resetn;
  logic [15:0]   key_in;
  logic          key_valid;
  logic          lock_req;
  logic          relock;
  logic          scan_mode;
  logic          Lock;
  logic          debug_unlocked;
  logic          lockout;
  logic [FW-1:0] fail_cnt;

  debug_unlock_ctrl #(
    .DW            (16),
    .KEY0          (K0),
    .KEY1          (K1),
    .TIMEOUT       (TIMEOUT),
    .UNLOCK_CYCLES (UC),
    .MAX_FAILS     (MAXF),
    .FW            (FW)
  ) dut (
    .Clk            (Clk),
    .resetn         (resetn),
    .key_in         (key_in),
    .key_valid      (key_valid),
    .lock_req       (lock_req),
    .relock         (relock),
    .scan_mode      (scan_mode),
    .Lock           (Lock),
    .debug_unlocked (debug_unlocked),
    .lockout        (lockout),
    .fail_cnt       (fail_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef logic [FW+2:0] vec_t;

  vec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   t = 0;

  // reference model: absolute edge deadlines instead of counters
  bit m_wait, m_unl, m_lo, m_ldone, m_lock;
  int m_k0, m_uend, m_fails;

  task automatic step(input logic rn, input logic kv,
                      input logic [15:0] k, input logic lr,
                      input logic rl, input logic sc);
    bit fail;
    bit new_lo;
    fail = 0;
    new_lo = 0;
    resetn = rn; key_valid = kv; key_in = k;
    lock_req = lr; relock = rl; scan_mode = sc;
    t++;
    if (!rn) begin
      m_wait = 0; m_unl = 0; m_lo = 0;
      m_fails = 0; m_ldone = 0; m_lock = 0;
    end else begin
      if (m_lo) begin
      end else if (sc) begin
        m_wait = 0;
        m_unl = 0;
      end else if (m_unl) begin
        if (lr || rl || t >= m_uend) m_unl = 0;
      end else if (m_wait) begin
        if (kv) begin
          m_wait = 0;
          if (k == K1) begin
            m_unl = 1;
            m_uend = t + UC;
            m_fails = 0;
          end else fail = 1;
        end else if (t - m_k0 >= TIMEOUT) begin
          m_wait = 0;
          fail = 1;
        end
      end else if (kv) begin
        if (k == K0) begin
          m_wait = 1;
          m_k0 = t;
        end else fail = 1;
      end
      if (fail) begin
        if (m_fails < MAXF) m_fails++;
        if (m_fails == MAXF) begin
          m_lo = 1;
          new_lo = 1;
        end
      end
      m_lock = (lr || new_lo) && !m_ldone;
      if (lr || new_lo) m_ldone = 1;
    end
    @(posedge Clk);
    exp_q.push_back({m_lock, m_unl, m_lo, FW'(m_fails)});
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 16'h0, 0, 0, 0);
  endtask

  task automatic key(input logic [15:0] k);
    step(1, 1, k, 0, 0, 0);
  endtask

  always @(negedge Clk) begin : monitor
    vec_t e;
    vec_t got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {Lock, debug_unlocked, lockout, fail_cnt};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL outputs t=%0d got %b required %b",
                 t, got, e);
      end
    end
  end

  initial begin
    logic       kv, lr, rl, sc, rn;
    logic [15:0] k;
    int sel;
    step(0, 0, 16'h0, 0, 0, 0);
    step(0, 0, 16'h0, 0, 0, 0);
    // good sequence
    idle(5); key(K0); idle(1); key(K1); idle(UC + 4);
    // timeout, late KEY1, then a clean unlock
    key(K0); idle(TIMEOUT); idle(1); key(K1);
    key(K0); key(K1); idle(UC + 2);
    // KEY1 on the last timer cycle, relock on expiry edge
    key(K0); idle(TIMEOUT - 1); key(K1);
    idle(UC - 1); step(1, 0, 16'h0, 0, 1, 0); idle(3);
    // lock_req held, then lock_req ends a window
    for (int i = 0; i < 5; i++) step(1, 0, 16'h0, 1, 0, 0);
    idle(2); key(K0); key(K1); idle(10);
    step(1, 0, 16'h0, 1, 0, 0); idle(3);
    // scan abort and scan blocking an unlock
    key(K0); key(K1); idle(5);
    step(1, 0, 16'h0, 0, 0, 1);
    step(1, 1, K0, 0, 0, 1);
    step(1, 1, K1, 0, 0, 1); idle(3);
    // mid-window reset
    key(K0); key(K1); idle(5);
    step(0, 0, 16'h0, 0, 0, 0); idle(2);
    // lockout then reset
    key(16'h0000); key(16'h0000); key(16'h0000);
    key(K0); key(K1); idle(3);
    step(0, 0, 16'h0, 0, 0, 0); idle(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      kv = ($urandom_range(0, 9) < 4);
      sel = $urandom_range(0, 3);
      k = (sel == 0) ? K0 : (sel == 1) ? K1 :
          (sel == 2) ? K0 : 16'($urandom);
      sc = ($urandom_range(0, 19) == 0);
      rn = ($urandom_range(0, 49) != 0);
      lr = 0;
      rl = 0;
      if (m_unl || (!m_wait && !kv)) begin
        lr = ($urandom_range(0, 14) == 0);
        rl = ($urandom_range(0, 14) == 0);
      end
      step(rn, kv, k, lr, rl, sc);
    end
    idle(2);
    @(negedge Clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain left=%0d required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/debug_unlock_ctrl.md
Name: debug_unlock_ctrl

Overview:
- Upstream control stage for the lockable data register. It generates the register's `Lock` pulse and its `debug_unlocked` enable.
- `debug_unlocked` is granted only after a two-word key sequence arrives within a time window. It is held for a bounded number of cycles.
- Repeated bad attempts drive a terminal lockout that only reset clears.
- `scan_mode` always aborts any unlock in progress.

Parameters:
- DW, 16, key word width
- KEY0, 16'hA5C3, first key word
- KEY1, 16'h3C5A, second key word
- TIMEOUT, 8, max cycles allowed from KEY0 acceptance to KEY1 arrival (>=1)
- UNLOCK_CYCLES, 64, cycles `debug_unlocked` stays high (>=1)
- MAX_FAILS, 3, failed attempts that trigger lockout (>=1)
- FW, $clog2(MAX_FAILS+1), fail counter width

Ports:
- Clk, input, 1, clock, rising edge
- resetn, input, 1, reset, synchronous, active-low
- key_in, input, DW, key word, sampled only when key_valid=1
- key_valid, input, 1, one key word presented this cycle
- lock_req, input, 1, software request to lock the register
- relock, input, 1, end an active unlock window early
- scan_mode, input, 1, scan active
- Lock, output, 1, one-cycle pulse to the locked register
- debug_unlocked, output, 1, level, high only in state UNLOCKED
- lockout, output, 1, high only in state LOCKOUT
- fail_cnt, output, FW, failed-attempt count, saturates at MAX_FAILS

Behaviour:
- Reset: one clock; reset is synchronous and active-low (Clk, resetn). resetn=0 sampled at a Clk edge sets:
  - state = IDLE
  - Lock = 0, debug_unlocked = 0, lockout = 0, fail_cnt = 0
  - timers = 0, lock_issued = 0
- Reset mid-sequence or mid-window drops every output the following cycle.
- All outputs are registered; none is combinational from an input.
- States: IDLE, WAIT_K1, UNLOCKED, LOCKOUT.
- IDLE:
  - key_valid & key_in==KEY0 -> WAIT_K1; clear timer.
  - key_valid & key_in!=KEY0 -> fail.
- WAIT_K1:
  - key_valid & key_in==KEY1 -> UNLOCKED; load window = UNLOCK_CYCLES; clear fail_cnt.
  - key_valid & key_in!=KEY1 (including a repeated KEY0) -> fail; go to IDLE.
  - No key_valid: timer increments each cycle. When timer == TIMEOUT-1 -> fail; go to IDLE.
  - KEY1 accepted at timer == TIMEOUT-1 succeeds: the key match takes priority over the timeout.
- UNLOCKED:
  - debug_unlocked = 1. window decrements each cycle; key_valid is ignored.
  - Exit to IDLE when the window reaches 1, or when relock=1, or when lock_req=1. No fail is counted.
  - Timing: KEY1 sampled at edge N -> debug_unlocked high for edges N..N+UNLOCK_CYCLES-1 -> low after edge N+UNLOCK_CYCLES.
- fail:
  - fail_cnt increments, saturating.
  - If the new value == MAX_FAILS -> LOCKOUT (overrides any IDLE target).
- LOCKOUT:
  - Terminal until reset. lockout = 1, debug_unlocked = 0.
  - All key, relock and scan inputs are ignored.
- scan_mode=1 in any state except LOCKOUT:
  - Forces IDLE next cycle, clears timers, counts no fail.
  - Takes priority over a simultaneous key match; no unlock can occur while scan_mode=1.
- Lock pulse:
  - Pulses 1 for exactly one cycle, on the first lock_req=1 sampled after reset, or on entry to LOCKOUT, whichever comes first.
  - lock_issued is sticky, so there is never a second pulse before reset.
  - lock_req held high yields one pulse.
  - Lock rises the cycle after the edge that sampled the trigger.
- Priority order per cycle: reset > LOCKOUT hold > scan_mode > lock_req/relock > key match > timeout.

Decomposition:
- Shared package `lock_ctrl_pkg` holds:
  - state enum (IDLE/WAIT_K1/UNLOCKED/LOCKOUT)
  - default key constants
  - the FW computation helper
- One natural sub-module: `sat_down_counter`, a loadable down counter with an expiry flag. It is instantiated for the unlock window.
- The TIMEOUT timer is an inline up counter.

Test Plan:
- Good sequence: KEY0 at cycle 10, KEY1 at cycle 12 -> debug_unlocked high for exactly 64 cycles starting cycle 13; fail_cnt=0.
- Timeout: KEY0 at cycle 10, no key for 8 cycles -> IDLE at cycle 18; fail_cnt=1; KEY1 at cycle 20 -> no unlock, fail_cnt=2.
- Lockout: three wrong words 16'h0000 -> lockout=1 and a single Lock pulse the cycle after the third; a subsequent KEY0,KEY1 -> debug_unlocked stays 0; resetn=0 -> all clear.
- Scan abort: unlock granted, then scan_mode=1 at cycle 30 -> debug_unlocked=0 from cycle 31; KEY0,KEY1 presented with scan_mode=1 -> no unlock, fail_cnt unchanged.
- Lock pulse: lock_req held high for 5 cycles -> Lock high exactly 1 cycle; a later lock_req -> no pulse; lock_req during UNLOCKED ends the window next cycle.
- Boundary: KEY1 arriving at timer=TIMEOUT-1 -> unlock granted; relock and window expiry in the same cycle -> single clean exit to IDLE; mid-window reset -> outputs 0 next cycle.
